// File: rtl/se_selfcomp_monitor.sv
// Self-composition timing-leak monitor: pairs the accepted outputs of two SE copies.
// Define SE_VALUE_CHECK_EN to store results in the skew buffer and compare paired values.
module se_selfcomp_monitor #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    parameter int TXN_LIMIT = 16,
    localparam int SW       = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             io_out_ready,
    input  logic             io_out_validOne,
    input  logic [WIDTH-1:0] io_out_resultOne,
    input  logic             io_out_validTwo,
    input  logic [WIDTH-1:0] io_out_resultTwo,
    output logic             bothValid,
    output logic             timingLeak,
    output logic             timingLeakDone,
    output logic             overflow,
    output logic [CNT_W-1:0] leakCycle,
    output logic [SW-1:0]    maxSkew,
    output logic [CNT_W-1:0] txnCount,
    output logic             valueMismatch
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] txn_q, txn_d, txn_inc;
    logic [CNT_W-1:0] lcyc_q, lcyc_d;
    logic [SW-1:0]    max_q, max_d;
    logic [SW-1:0]    skew_q, skew_d;
    logic             leak_q, leak_d;
    logic             ovf_q, ovf_d;
    logic             lead_q, lead_d;
    logic             fire1, fire2, lead_fire, lag_fire;
    logic             push, pop, pair;

    assign fire1     = io_out_validOne & io_out_ready;
    assign fire2     = io_out_validTwo & io_out_ready;
    // lead_q = 1 means copy one is ahead and owns the buffered entries
    assign lead_fire = lead_q ? fire1 : fire2;
    assign lag_fire  = lead_q ? fire2 : fire1;
    assign txn_inc   = txn_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        txn_d   = txn_q;
        lcyc_d  = lcyc_q;
        max_d   = max_q;
        skew_d  = skew_q;
        leak_d  = leak_q;
        ovf_d   = ovf_q;
        lead_d  = lead_q;
        push    = 1'b0;
        pop     = 1'b0;
        pair    = 1'b0;
        if (start) begin
            state_d = RUN;
            cyc_d   = '0;
            txn_d   = '0;
            lcyc_d  = '0;
            max_d   = '0;
            skew_d  = '0;
            leak_d  = 1'b0;
            ovf_d   = 1'b0;
            lead_d  = 1'b0;
        end else if (state_q == RUN) begin
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
            if ((fire1 != fire2) && !leak_q) begin
                leak_d = 1'b1;
                lcyc_d = cyc_q;
            end
            if (skew_q == '0) begin
                if (fire1 && fire2) begin
                    pair = 1'b1;
                end else if (fire1 || fire2) begin
                    push   = 1'b1;
                    lead_d = fire1;
                    skew_d = SW'(1);
                end
            end else if (lead_fire && lag_fire) begin
                push = 1'b1;
                pop  = 1'b1;
                pair = 1'b1;
            end else if (lead_fire) begin
                if (skew_q == SW'(DEPTH)) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    push   = 1'b1;
                    skew_d = skew_q + 1'b1;
                end
            end else if (lag_fire) begin
                pop    = 1'b1;
                pair   = 1'b1;
                skew_d = skew_q - 1'b1;
            end
            if (skew_d > max_q) max_d = skew_d;
            if (pair) begin
                txn_d = txn_inc;
                if (txn_inc == CNT_W'(TXN_LIMIT)) state_d = DONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            txn_q   <= '0;
            lcyc_q  <= '0;
            max_q   <= '0;
            skew_q  <= '0;
            leak_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            txn_q   <= txn_d;
            lcyc_q  <= lcyc_d;
            max_q   <= max_d;
            skew_q  <= skew_d;
            leak_q  <= leak_d;
            ovf_q   <= ovf_d;
            lead_q  <= lead_d;
        end
    end

`ifdef SE_VALUE_CHECK_EN
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic             vmis_q, vmis_d;
    logic [WIDTH-1:0] head, lead_res, lag_res, push_data;

    assign head      = mem_q[rd_q];
    assign lead_res  = lead_q ? io_out_resultOne : io_out_resultTwo;
    assign lag_res   = lead_q ? io_out_resultTwo : io_out_resultOne;
    assign push_data = (skew_q == '0)
                     ? (fire1 ? io_out_resultOne : io_out_resultTwo)
                     : lead_res;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        vmis_d = vmis_q;
        if (start) begin
            wr_d   = '0;
            rd_d   = '0;
            vmis_d = 1'b0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (pair) begin
                if (skew_q == '0) begin
                    if (io_out_resultOne != io_out_resultTwo) vmis_d = 1'b1;
                end else if (head != lag_res) begin
                    vmis_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            vmis_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            vmis_q <= vmis_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by the pointers and skew_q
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= push_data;
    end

    assign valueMismatch = vmis_q;
`else
    logic unused_data;
    assign unused_data   = ^{io_out_resultOne, io_out_resultTwo, push, pop};
    assign valueMismatch = 1'b0;
`endif

    assign bothValid      = io_out_validOne & io_out_validTwo;
    assign timingLeak     = leak_q;
    assign timingLeakDone = (state_q == DONE);
    assign overflow       = ovf_q;
    assign leakCycle      = lcyc_q;
    assign maxSkew        = max_q;
    assign txnCount       = txn_q;

endmodule

// File: tb/tb_se_selfcomp_monitor.sv
// Testbench for se_selfcomp_monitor: directed scenarios plus randomized
// stimulus against a queue-based pairing model.
module tb_se_selfcomp_monitor;

    localparam int W  = 128;
    localparam int D  = 4;
    localparam int CW = 16;
    localparam int TL = 16;
    localparam int SW = $clog2(D) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          rdy = 1'b0;
    logic          v1 = 1'b0;
    logic          v2 = 1'b0;
    logic [W-1:0]  r1 = '0;
    logic [W-1:0]  r2 = '0;
    logic          bothValid, timingLeak, timingLeakDone, overflow, valueMismatch;
    logic [CW-1:0] leakCycle, txnCount;
    logic [SW-1:0] maxSkew;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    se_selfcomp_monitor #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .TXN_LIMIT(TL)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .io_out_ready    (rdy),
        .io_out_validOne (v1),
        .io_out_resultOne(r1),
        .io_out_validTwo (v2),
        .io_out_resultTwo(r2),
        .bothValid       (bothValid),
        .timingLeak      (timingLeak),
        .timingLeakDone  (timingLeakDone),
        .overflow        (overflow),
        .leakCycle       (leakCycle),
        .maxSkew         (maxSkew),
        .txnCount        (txnCount),
        .valueMismatch   (valueMismatch)
    );

    // Reference model: per-copy result queues; a pair forms whenever both queues hold data
    int          m_state;
    int          m_cyc, m_txn, m_lcyc, m_max, c1, c2;
    bit          m_leak, m_ovf, m_vm;
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    task automatic model_clear();
        m_cyc = 0; m_txn = 0; m_lcyc = 0; m_max = 0; c1 = 0; c2 = 0;
        m_leak = 0; m_ovf = 0; m_vm = 0;
        q1.delete(); q2.delete();
    endtask

    task automatic model_step(input bit st, input bit f1, input bit f2,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        int d;
        logic [W-1:0] x, y;
        if (st) begin
            model_clear();
            m_state = 1;
            return;
        end
        if (m_state != 1) return;
        if (f1 != f2 && !m_leak) begin
            m_leak = 1;
            m_lcyc = m_cyc;
        end
        if (m_cyc < (1 << CW) - 1) m_cyc++;
        d = (c1 + int'(f1)) - (c2 + int'(f2));
        if (d > D || d < -D) begin
            m_ovf = 1;
            m_state = 2;
            return;
        end
        c1 += int'(f1);
        c2 += int'(f2);
        if (f1) q1.push_back(a);
        if (f2) q2.push_back(b);
        if (q1.size() > 0 && q2.size() > 0) begin
            x = q1.pop_front();
            y = q2.pop_front();
`ifdef SE_VALUE_CHECK_EN
            if (x !== y) m_vm = 1;
`else
            if (x !== y) m_vm = 0;
`endif
            m_txn++;
            if (m_txn == TL) m_state = 2;
        end
        d = c1 - c2;
        if (d < 0) d = -d;
        if (d > m_max) m_max = d;
    endtask

    task automatic drive(input bit st, input bit rd, input bit a1, input logic [W-1:0] x1,
                         input bit a2, input logic [W-1:0] x2);
        @(negedge clock);
        start = st; rdy = rd; v1 = a1; r1 = x1; v2 = a2; r2 = x2;
        @(posedge clock);
        model_step(st, a1 & rd, a2 & rd, x1, x2);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        start = 0; rdy = 0; v1 = 0; v2 = 0;
        reset = 1;
        m_state = 0;
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if ({timingLeak, timingLeakDone, overflow, valueMismatch} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000",
                     {timingLeak, timingLeakDone, overflow, valueMismatch});
        end
        n_tests++;
        if ({leakCycle, maxSkew, txnCount} !== '0) begin
            n_fail++;
            $display("FAIL reset_counts got lc=%0d ms=%0d tx=%0d want 0",
                     leakCycle, maxSkew, txnCount);
        end
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_lockstep();
        logic [W-1:0] x;
        drive(1, 1, 0, '0, 0, '0);
        for (int i = 0; i < TL; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            drive(0, 1, 1, x, 1, x);
            if (i == TL - 2) begin
                n_tests++;
                if (timingLeakDone !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lockstep_early_done got %b want 0", timingLeakDone);
                end
            end
        end
        n_tests++;
        if (txnCount !== CW'(TL) || timingLeakDone !== 1'b1) begin
            n_fail++;
            $display("FAIL lockstep_done got tx=%0d done=%b want tx=%0d done=1",
                     txnCount, timingLeakDone, TL);
        end
        n_tests++;
        if (timingLeak !== 1'b0 || maxSkew !== '0) begin
            n_fail++;
            $display("FAIL lockstep_noleak got leak=%b ms=%0d want 0 0", timingLeak, maxSkew);
        end
    endtask

    task automatic test_skew();
        logic [W-1:0] x;
        drive(1, 1, 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, '0, 0, '0);
        x = W'(128'h1234);
        drive(0, 1, 1, x, 0, '0);
        drive(0, 1, 0, '0, 1, x);
        for (int i = 0; i < TL - 1; i++) drive(0, 1, 1, W'(i), 1, W'(i));
        n_tests++;
        if (timingLeak !== 1'b1 || leakCycle !== CW'(3)) begin
            n_fail++;
            $display("FAIL skew_leak got leak=%b lc=%0d want 1 3", timingLeak, leakCycle);
        end
        n_tests++;
        if (maxSkew !== SW'(1) || txnCount !== CW'(TL) || timingLeakDone !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_pairs got ms=%0d tx=%0d done=%b want 1 %0d 1",
                     maxSkew, txnCount, timingLeakDone, TL);
        end
    endtask

    task automatic test_overflow();
        drive(1, 1, 0, '0, 0, '0);
        for (int i = 0; i < D; i++) drive(0, 1, 1, W'(i), 0, '0);
        n_tests++;
        if (overflow !== 1'b0 || timingLeakDone !== 1'b0 || maxSkew !== SW'(D)) begin
            n_fail++;
            $display("FAIL ovf_full got ovf=%b done=%b ms=%0d want 0 0 %0d",
                     overflow, timingLeakDone, maxSkew, D);
        end
        drive(0, 1, 1, W'(9), 0, '0);
        n_tests++;
        if (overflow !== 1'b1 || timingLeakDone !== 1'b1 || txnCount !== '0) begin
            n_fail++;
            $display("FAIL ovf_set got ovf=%b done=%b tx=%0d want 1 1 0",
                     overflow, timingLeakDone, txnCount);
        end
    endtask

    task automatic test_ready_gating();
        drive(1, 1, 0, '0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, W'(5), 1, W'(5));
            n_tests++;
            if (bothValid !== 1'b1) begin
                n_fail++;
                $display("FAIL gate_bothvalid cycle %0d got %b want 1", i, bothValid);
            end
        end
        n_tests++;
        if (txnCount !== '0 || timingLeak !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_blocked got tx=%0d leak=%b want 0 0", txnCount, timingLeak);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, 1, W'(5), 1, W'(5));
        n_tests++;
        if (txnCount !== CW'(3) || timingLeak !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_open got tx=%0d leak=%b want 3 0", txnCount, timingLeak);
        end
    endtask

    task automatic test_value();
        bit exp_vm;
`ifdef SE_VALUE_CHECK_EN
        exp_vm = 1;
`else
        exp_vm = 0;
`endif
        drive(1, 1, 0, '0, 0, '0);
        drive(0, 1, 1, W'(7), 1, W'(7));
        drive(0, 1, 1, W'(4), 0, '0);
        drive(0, 1, 0, '0, 0, '0);
        n_tests++;
        if (valueMismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL value_before got %b want 0", valueMismatch);
        end
        drive(0, 1, 0, '0, 1, W'(5));
        n_tests++;
        if (valueMismatch !== exp_vm || txnCount !== CW'(2)) begin
            n_fail++;
            $display("FAIL value_pair2 got vm=%b tx=%0d want %b 2", valueMismatch, txnCount, exp_vm);
        end
    endtask

    task automatic test_restart();
        drive(1, 1, 0, '0, 0, '0);
        drive(0, 1, 0, '0, 0, '0);
        drive(0, 1, 1, W'(1), 0, '0);
        drive(0, 1, 1, W'(2), 0, '0);
        n_tests++;
        if (timingLeak !== 1'b1 || leakCycle !== CW'(1)) begin
            n_fail++;
            $display("FAIL restart_leak got leak=%b lc=%0d want 1 1", timingLeak, leakCycle);
        end
        do_reset();
        n_tests++;
        if ({timingLeak, timingLeakDone, overflow, valueMismatch, leakCycle, maxSkew, txnCount}
            !== '0) begin
            n_fail++;
            $display("FAIL restart_reset got leak=%b lc=%0d ms=%0d tx=%0d want all 0",
                     timingLeak, leakCycle, maxSkew, txnCount);
        end
        @(negedge clock);
        reset = 0;
        drive(1, 1, 0, '0, 0, '0);
        drive(0, 1, 0, '0, 1, W'(3));
        n_tests++;
        if (timingLeak !== 1'b1 || leakCycle !== '0 || maxSkew !== SW'(1)) begin
            n_fail++;
            $display("FAIL restart_run got leak=%b lc=%0d ms=%0d want 1 0 1",
                     timingLeak, leakCycle, maxSkew);
        end
        drive(1, 1, 0, '0, 0, '0);
        n_tests++;
        if (timingLeak !== 1'b0 || maxSkew !== '0 || timingLeakDone !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_start got leak=%b ms=%0d done=%b want 0 0 0",
                     timingLeak, maxSkew, timingLeakDone);
        end
    endtask

    task automatic test_random();
        bit st, rd, a1, a2;
        logic [W-1:0] x1, x2;
        logic [3+2*CW+SW:0] got, exp;
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            st = (i == 0) || ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 3) != 0);
            a1 = $urandom_range(0, 1);
            a2 = ($urandom_range(0, 2) == 0) ? ~a1 : a1;
            x1 = W'($urandom_range(0, 7));
            x2 = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 7)) : x1;
            drive(st, rd, a1, x1, a2, x2);
            got = {timingLeak, timingLeakDone, overflow, valueMismatch,
                   leakCycle, maxSkew, txnCount};
            exp = {m_leak, (m_state == 2), m_ovf, m_vm,
                   CW'(m_lcyc), SW'(m_max), CW'(m_txn)};
            n_tests++;
            if (got !== exp || bothValid !== (a1 & a2)) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random cycle %0d got %h bv=%b want %h bv=%b",
                             i, got, bothValid, exp, a1 & a2);
                bad++;
            end
        end
    endtask

    initial begin
        m_state = 0;
        model_clear();
        test_reset();
        test_lockstep();
        test_skew();
        test_overflow();
        test_ready_gating();
        test_value();
        test_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/se_selfcomp_monitor.md
# se_selfcomp_monitor

Parametrised self-composition monitor for the SE timing-leak harness. Observes the output streams of two SE copies driven with identical public inputs and a shared out_ready, and flags a timing leak on the first cycle their accepted outputs diverge. A skew buffer re-aligns the two streams so transactions are still paired and counted after divergence, giving leak cycle, maximum skew and a completion flag.

## Interface
- WIDTH, 128: result width of each SE copy
- DEPTH, 4: skew-buffer entries; power of two, ≥2
- CNT_W, 16: width of the cycle and transaction counters
- TXN_LIMIT, 16: matched pairs observed before DONE; 1..2^CNT_W-1
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  clear all statistics and enter RUN
- io_out_ready  in  1  shared ready to both copies
- io_out_validOne  in  1  copy-one valid
- io_out_resultOne  in  WIDTH  copy-one result
- io_out_validTwo  in  1  copy-two valid
- io_out_resultTwo  in  WIDTH  copy-two result
- bothValid  out  1  validOne & validTwo, combinational
- timingLeak  out  1  sticky: accepted outputs diverged in time
- timingLeakDone  out  1  state == DONE
- overflow  out  1  sticky: skew exceeded DEPTH
- leakCycle  out  CNT_W  RUN cycle index of first divergence
- maxSkew  out  $clog2(DEPTH)+1  largest |fires1 − fires2| seen
- txnCount  out  CNT_W  matched pairs completed
- valueMismatch  out  1  sticky, see Configuration

## Operation
- Fire: fireX = io_out_validX & io_out_ready.
- States: IDLE (reset), RUN, DONE. start in any state → RUN, clearing cycle counter, txnCount, leakCycle, maxSkew, skew buffer, all sticky flags. IDLE/DONE ignore fires.
- RUN: cycle counter increments every cycle (saturates at all-ones).
- Leak: fire1 != fire2 in RUN with timingLeak=0 → set timingLeak, leakCycle = current cycle counter (value before increment).
- Skew d = fires1 − fires2 (signed). Buffer holds entries of the leading side (sign of d).
- d=0, both fire: pair completes directly, no buffer op.
- d=0, one fires: push that side's entry, it becomes leader, |d|=1.
- d≠0, only leader fires: push, |d|+1. Only lagger fires: pop head, pair completes, |d|−1; at 0 buffer empty, no leader.
- d≠0, both fire: push leader's and pop head same cycle, d unchanged.
- Push with |d|=DEPTH: overflow set, → DONE, entry dropped.
- maxSkew = max(maxSkew, |d| after update).
- Each completed pair: txnCount+1; reaching TXN_LIMIT → DONE same edge.
- Reset mid-RUN: everything to reset values, IDLE.

## Timing
- Reset values: timingLeak, timingLeakDone, overflow, valueMismatch 0; leakCycle, maxSkew, txnCount 0; buffer empty; state IDLE.
- All outputs except bothValid registered; reflect a fire one cycle after the edge sampling it.
- start sampled on rising edge; first RUN cycle (counter 0) is the cycle after.
- A fire coincident with start is ignored.
- timingLeakDone asserts the cycle after the final pair or overflow, holds until start or reset.

## Configuration
- SE_VALUE_CHECK_EN defined: buffer stores WIDTH-bit results; each completed pair compares the two results (directly when d=0, else head vs lagger); any difference sets valueMismatch sticky.
- Not defined: buffer keeps only the occupancy counter, no data storage; valueMismatch tied 0.

## Test plan
- Lockstep: both fire together 16 times, ready=1 → txnCount=16, timingLeakDone=1, timingLeak=0, maxSkew=0.
- Single-cycle skew: copy one fires RUN cycle 3, copy two cycle 4, then lockstep → timingLeak=1, leakCycle=3, maxSkew=1, pairs still reach 16.
- Overflow: copy one fires 5 times, copy two silent, DEPTH=4 → overflow=1, DONE after 5th fire, txnCount=0.
- Ready gating: both valid, ready=0 for 10 cycles then 1 → no leak, bothValid=1 throughout, counts only on ready.
- Value check (macro on): copy two result 0x5 vs copy one 0x4 on pair 2, 2 cycles late → valueMismatch=1; macro off → 0.
- Reset/start mid-RUN with leak set → all outputs 0; start again → RUN from counter 0.
